// File: rtl/reg_writeback.sv
// Write-back queue feeding the register file write port, with read-after-write hazard flags.
// Optional forwarding outputs are enabled with REG_WRITEBACK_FWD_EN.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       iClk,
  input  logic                       nRst,
  input  logic                       iAluValid,
  output logic                       oAluReady,
  input  logic [AW-1:0]              iAluAddr,
  input  logic [DW-1:0]              iAluData,
  input  logic                       iLdValid,
  output logic                       oLdReady,
  input  logic [AW-1:0]              iLdAddr,
  input  logic [DW-1:0]              iLdData,
  input  logic                       iStall,
  output logic                       oWrite,
  output logic [AW-1:0]              oAddrC,
  output logic [DW-1:0]              oRegC,
  input  logic [AW-1:0]              iAddrA,
  input  logic [AW-1:0]              iAddrB,
  output logic                       oHazA,
  output logic                       oHazB,
`ifdef REG_WRITEBACK_FWD_EN
  output logic                       oFwdA,
  output logic                       oFwdB,
  output logic [DW-1:0]              oFwdDataA,
  output logic [DW-1:0]              oFwdDataB,
`endif
  output logic [$clog2(DEPTH+1)-1:0] oCount
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic          space, acc_ld, acc_alu, push, pop;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;

  assign space     = (oCount < CW'(DEPTH));
  assign oLdReady  = space;
  assign oAluReady = space && !iLdValid;
  assign acc_ld    = iLdValid && space;
  assign acc_alu   = iAluValid && oAluReady;
  assign push_addr = acc_ld ? iLdAddr : iAluAddr;
  assign push_data = acc_ld ? iLdData : iAluData;
  // Results to r0 finish their handshake but never occupy a slot.
  assign push      = (acc_ld || acc_alu) && (push_addr != '0);
  assign pop       = (oCount != '0) && !iStall;

  always_ff @(posedge iClk) begin
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      head   <= '0;
      tail   <= '0;
      oCount <= '0;
      oWrite <= 1'b0;
      oAddrC <= '0;
      oRegC  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   oCount <= oCount + 1'b1;
        2'b01:   oCount <= oCount - 1'b1;
        default: oCount <= oCount;
      endcase
      oWrite <= pop;
      if (pop) begin
        oAddrC <= addr_q[head];
        oRegC  <= data_q[head];
      end
    end
  end

  // Scan oldest (output register) to youngest so the last match wins for forwarding.
  logic          hit_a, hit_b;
  logic [DW-1:0] fwd_data_a, fwd_data_b;
  logic [PW-1:0] idx;

  always_comb begin
    hit_a      = 1'b0;
    hit_b      = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    idx        = '0;
    if (oWrite && oAddrC == iAddrA) begin
      hit_a      = 1'b1;
      fwd_data_a = oRegC;
    end
    if (oWrite && oAddrC == iAddrB) begin
      hit_b      = 1'b1;
      fwd_data_b = oRegC;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < oCount) begin
        if (addr_q[idx] == iAddrA) begin
          hit_a      = 1'b1;
          fwd_data_a = data_q[idx];
        end
        if (addr_q[idx] == iAddrB) begin
          hit_b      = 1'b1;
          fwd_data_b = data_q[idx];
        end
      end
    end
    if (iAddrA == '0) hit_a = 1'b0;
    if (iAddrB == '0) hit_b = 1'b0;
  end

`ifdef REG_WRITEBACK_FWD_EN
  assign oFwdA     = hit_a;
  assign oFwdB     = hit_b;
  assign oFwdDataA = fwd_data_a;
  assign oFwdDataB = fwd_data_b;
  assign oHazA     = hit_a && !oFwdA;
  assign oHazB     = hit_b && !oFwdB;
`else
  assign oHazA     = hit_a;
  assign oHazB     = hit_b;
  logic unused_fwd;
  assign unused_fwd = ^{fwd_data_a, fwd_data_b};
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback (default build): handshake, ordering, stall, r0 drop,
// hazards and asynchronous reset.
module tb_reg_writeback;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          iClk, nRst;
  logic          iAluValid, oAluReady, iLdValid, oLdReady, iStall, oWrite, oHazA, oHazB;
  logic [AW-1:0] iAluAddr, iLdAddr, oAddrC, iAddrA, iAddrB;
  logic [DW-1:0] iAluData, iLdData, oRegC;
  logic [2:0]    oCount;

  int n_checks = 0;
  int n_fail   = 0;

  reg_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .iClk(iClk), .nRst(nRst),
    .iAluValid(iAluValid), .oAluReady(oAluReady), .iAluAddr(iAluAddr), .iAluData(iAluData),
    .iLdValid(iLdValid), .oLdReady(oLdReady), .iLdAddr(iLdAddr), .iLdData(iLdData),
    .iStall(iStall), .oWrite(oWrite), .oAddrC(oAddrC), .oRegC(oRegC),
    .iAddrA(iAddrA), .iAddrB(iAddrB), .oHazA(oHazA), .oHazB(oHazB), .oCount(oCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, "_wr"}, oWrite, 1);
    check({tag, "_addr"}, oAddrC, a);
    check({tag, "_data"}, oRegC, d);
  endtask

  initial begin
    nRst = 0; iAluValid = 0; iAluAddr = 0; iAluData = 0;
    iLdValid = 0; iLdAddr = 0; iLdData = 0; iStall = 0; iAddrA = 0; iAddrB = 0;
    #12;
    check("rst_count", oCount, 0);
    check("rst_write", oWrite, 0);
    check("rst_addr", oAddrC, 0);
    check("rst_data", oRegC, 0);
    nRst = 1;
    tick();

    // single ALU push, two-edge latency
    iAluValid = 1; iAluAddr = 5; iAluData = 32'hDEADBEEF;
    #1 check("t1_alu_ready", oAluReady, 1);
    tick();
    iAluValid = 0;
    check("t1_count1", oCount, 1);
    check("t1_nowr_yet", oWrite, 0);
    tick();
    expect_wr("t1", 5, 32'hDEADBEEF);
    check("t1_count0", oCount, 0);
    tick();
    check("t1_wr_drop", oWrite, 0);

    // load priority over ALU
    iLdValid = 1; iLdAddr = 3; iLdData = 32'h11;
    iAluValid = 1; iAluAddr = 4; iAluData = 32'h22;
    #1;
    check("t2_ld_ready", oLdReady, 1);
    check("t2_alu_ready", oAluReady, 0);
    tick();
    iLdValid = 0;
    #1 check("t2_alu_ready2", oAluReady, 1);
    tick();
    iAluValid = 0;
    expect_wr("t2_first", 3, 32'h11);
    check("t2_count_pushpop", oCount, 1);
    tick();
    expect_wr("t2_second", 4, 32'h22);
    tick();
    check("t2_idle", oWrite, 0);

    // fill under stall, then drain in order
    iStall = 1;
    for (int i = 1; i <= 4; i++) begin
      iAluValid = 1; iAluAddr = AW'(i); iAluData = 32'h100 + i;
      tick();
    end
    iAluAddr = 9; iAluData = 32'h999;
    #1;
    check("t3_full", oCount, 4);
    check("t3_ld_ready", oLdReady, 0);
    check("t3_alu_ready", oAluReady, 0);
    check("t3_stall_nowr", oWrite, 0);
    tick();
    iAluValid = 0;
    check("t3_still_full", oCount, 4);
    iStall = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_wr($sformatf("t3_drain%0d", i), AW'(i), 32'h100 + i);
    end
    check("t3_empty", oCount, 0);
    tick();
    check("t3_idle", oWrite, 0);

    // r0 result is dropped after handshake
    iAluValid = 1; iAluAddr = 0; iAluData = 32'hFFFFFFFF;
    #1 check("t4_r0_ready", oAluReady, 1);
    tick();
    iAluValid = 0;
    check("t4_r0_count", oCount, 0);
    check("t4_r0_nowr", oWrite, 0);
    tick();
    check("t4_r0_nowr2", oWrite, 0);
    iAddrA = 0;
    #1 check("t4_r0_haz", oHazA, 0);

    // hazards: pushing entry invisible, queued and output-register entries flag
    iStall = 1;
    iAluValid = 1; iAluAddr = 7; iAluData = 32'h77;
    iAddrA = 7; iAddrB = 8;
    #1 check("t5_push_invisible", oHazA, 0);
    tick();
    iAluValid = 0;
    #1;
    check("t5_hazA", oHazA, 1);
    check("t5_hazB", oHazB, 0);
    iAddrB = 7;
    #1 check("t5_hazB_queued", oHazB, 1);
    iStall = 0;
    tick();
    expect_wr("t5", 7, 32'h77);
    check("t5_haz_outreg", oHazA, 1);
    tick();
    check("t5_haz_clear", oHazA, 0);
    check("t5_hazB_clear", oHazB, 0);
    iAddrA = 0; iAddrB = 0;

    // async reset mid-operation
    iStall = 1;
    for (int i = 10; i <= 12; i++) begin
      iAluValid = 1; iAluAddr = AW'(i); iAluData = 32'h200 + i;
      tick();
    end
    iAluValid = 0;
    iStall = 0;
    check("t6_queued", oCount, 3);
    tick();
    expect_wr("t6_pre", 10, 32'h20A);
    #2 nRst = 0;
    #1;
    check("t6_rst_count", oCount, 0);
    check("t6_rst_write", oWrite, 0);
    #1 nRst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_no_wr%0d", i), oWrite, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-back queue that sits in front of the 32x32 register file and drives its single write port: oWrite, oAddrC and oRegC connect directly to the file's iWrite, iAddrC and iRegC.
- Accepts results from two producers (ALU and load unit) over valid/ready handshakes and buffers them in a small FIFO.
- Retires at most one result per clock to the register file.
- Reports read-after-write hazards for the file's two read addresses so the issue stage can stall.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 5, register address width
DW, 32, register data width

Ports:
iClk  input  1  clock, rising edge
nRst  input  1  asynchronous active-low reset
iAluValid  input  1  ALU result valid
oAluReady  output  1  ALU result accepted this cycle when high with iAluValid
iAluAddr  input  AW  ALU destination register
iAluData  input  DW  ALU result
iLdValid  input  1  load result valid
oLdReady  output  1  load result accepted when high with iLdValid
iLdAddr  input  AW  load destination register
iLdData  input  DW  load data
iStall  input  1  register-file write port unavailable; hold retirement
oWrite  output  1  write strobe to register file
oAddrC  output  AW  write address to register file
oRegC  output  DW  write data to register file
iAddrA  input  AW  read port A address (hazard check)
iAddrB  input  AW  read port B address (hazard check)
oHazA  output  1  pending write to iAddrA
oHazB  output  1  pending write to iAddrB
oCount  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (nRst low, asynchronous):
  - FIFO is emptied; oCount = 0.
  - oWrite = 0, oAddrC = 0, oRegC = 0.
  - All valid bits are cleared.
  - A reset mid-operation discards every queued result.
- Accept, combinational:
  - oLdReady = (oCount < DEPTH).
  - oAluReady = (oCount < DEPTH) && !iLdValid. Load has fixed priority; at most one accept per cycle.
  - A pop in the same cycle does not free space for a push.
- Enqueue:
  - An accepted result with address != 0 is written at the tail on the rising edge.
  - An accepted result with address 0 completes its handshake but is dropped. It is never enqueued and never written.
- Retire (pipeline register on the output):
  - Each edge with oCount > 0 and !iStall pops the head into the output register, setting oWrite = 1 with that head's address and data.
  - Otherwise oWrite = 0 next cycle; oAddrC and oRegC hold their last values.
- Latency: result accepted at edge N -> oWrite high in the cycle after edge N+1 -> register file updated at edge N+2, assuming no stall and an empty queue.
- Ordering: strict FIFO order, including across the two sources. Back-to-back writes to the same register retire oldest first.
- Throughput: sustained 1 result/cycle with simultaneous push and pop. oCount is unchanged on a simultaneous push+pop.
- Pointers: head and tail wrap modulo DEPTH. Full (oCount == DEPTH) and empty (oCount == 0) are distinguished by the count, not by pointer equality.
- Stall: iStall high freezes the head and drops oWrite the next cycle. Pushes continue until full.
- Hazard, combinational:
  - oHazA = (iAddrA != 0) && (iAddrA matches any valid FIFO entry || (oWrite && iAddrA == oAddrC)). oHazB is identical using iAddrB.
  - Address 0 never flags.
  - An entry being pushed in the current cycle is not yet visible to the check.

Optional Feature:
- Macro: REG_WRITEBACK_FWD_EN.
- Defined:
  - Adds outputs oFwdA and oFwdB (1 bit each) and oFwdDataA and oFwdDataB (DW each).
  - When an address hits, oFwdX = 1 and oFwdDataX = data of the youngest matching entry. The output register counts as the oldest entry.
  - oHazX is forced to 0 whenever oFwdX = 1.
- Undefined:
  - These ports do not exist.
  - Hazards behave as described in Behaviour.

Test Plan:
- Reset, then ALU push addr 5 data 0xDEADBEEF, iStall = 0 -> oWrite = 1, oAddrC = 5, oRegC = 0xDEADBEEF two edges after accept; oCount returns to 0.
- iLdValid and iAluValid both high (Ld addr 3 data 0x11, ALU addr 4 data 0x22) -> oLdReady = 1, oAluReady = 0; addr 3 retires first, addr 4 retires after its later accept.
- iStall = 1, push 4 results to addrs 1..4 -> oCount = 4, both readys = 0, oWrite = 0; release stall -> writes 1, 2, 3, 4 on four consecutive cycles.
- Push addr 0 data 0xFFFFFFFF -> handshake completes, oCount stays 0, oWrite never asserts; iAddrA = 0 -> oHazA = 0.
- Stall with addr 7 queued; iAddrA = 7, iAddrB = 8 -> oHazA = 1, oHazB = 0; after retire completes -> oHazA = 0.
- Queue 3 entries, pulse nRst low mid-cycle -> oCount = 0 and oWrite = 0 immediately; no further writes occur.
